// File: rtl/mem_pkg.sv
// Shared constants and types for the RV64 memory-access stage.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Lane-selects a doubleword of read data and sign/zero-extends it per the load funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] ext
);

  logic [63:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    ext = shifted;
    case (funct3)
      F3_B:    ext = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    ext = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    ext = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   ext = {56'h0, shifted[7:0]};
      F3_HU:   ext = {48'h0, shifted[15:0]};
      F3_WU:   ext = {32'h0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores over a req/ready handshake, stalls upstream while in flight,
// and hands aligned/extended results plus pass-through fields to the MEM/WB register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            mem_to_reg,
  input  logic            reg_write_en,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall,
  output logic            misalign_err,
  output logic [XLEN-1:0] data_out,
  output logic [XLEN-1:0] alu_out_out,
  output logic [4:0]      rd_out,
  output logic            mem_to_reg_out,
  output logic            reg_write_en_out
);

  mem_state_t      state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] ext_data;
  logic [2:0]      off;
  logic            is_mem;
  logic            misaligned;
  logic            bad;

  assign off    = alu_out[2:0];
  assign is_mem = mem_read | mem_write;

  // Size lives in funct3[1:0] for both loads and stores.
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  end

  assign bad = (mem_read & mem_write)
             | (mem_read & (funct3 == 3'b111))
             | (mem_write & funct3[2])
             | (is_mem & misaligned);

  assign mem_we   = mem_write;
  assign mem_addr = {alu_out[XLEN-1:3], 3'b000};

  always_comb begin
    mem_wstrb = 8'h00;
    mem_wdata = rs2_data;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          mem_wstrb = 8'h01 << off;
          mem_wdata = {8{rs2_data[7:0]}};
        end
        2'b01: begin
          mem_wstrb = 8'h03 << off;
          mem_wdata = {4{rs2_data[15:0]}};
        end
        2'b10: begin
          mem_wstrb = 8'h0F << off;
          mem_wdata = {2{rs2_data[31:0]}};
        end
        default: begin
          mem_wstrb = 8'hFF;
          mem_wdata = rs2_data;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .off    (off),
    .funct3 (funct3),
    .ext    (ext_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (is_mem && !bad) begin
          state_d = mem_ready ? StDone : StBusy;
        end
      end
      StBusy: begin
        if (mem_ready) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (mem_req && mem_ready) begin
      data_d = mem_read ? ext_data : '0;
    end
  end

  always_comb begin
    mem_req          = 1'b0;
    stall            = 1'b0;
    misalign_err     = 1'b0;
    data_out         = '0;
    reg_write_en_out = reg_write_en;
    alu_out_out      = alu_out;
    rd_out           = rd;
    mem_to_reg_out   = mem_to_reg;
    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          reg_write_en_out = 1'b0;
          if (bad) begin
            misalign_err = 1'b1;
          end else begin
            mem_req = 1'b1;
            stall   = 1'b1;
          end
        end
      end
      StBusy: begin
        mem_req          = 1'b1;
        stall            = 1'b1;
        reg_write_en_out = 1'b0;
      end
      StDone: begin
        data_out = data_q;
      end
      default: begin
        reg_write_en_out = 1'b0;
      end
    endcase
    // Reset kills handshake and writeback outputs immediately, not at the next edge.
    if (!reset_n) begin
      mem_req          = 1'b0;
      stall            = 1'b0;
      misalign_err     = 1'b0;
      data_out         = '0;
      reg_write_en_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage; load results are scoreboarded against a byte-level model.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [63:0] alu_out, rs2_data;
  logic [4:0]  rd;
  logic        mem_to_reg, reg_write_en;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        stall, misalign_err;
  logic [63:0] data_out, alu_out_out;
  logic [4:0]  rd_out;
  logic        mem_to_reg_out, reg_write_en_out;

  int n_vec;
  int n_err;
  logic [63:0] exp_q[$];

  mem_stage #(.XLEN(64)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .funct3           (funct3),
    .alu_out          (alu_out),
    .rs2_data         (rs2_data),
    .rd               (rd),
    .mem_to_reg       (mem_to_reg),
    .reg_write_en     (reg_write_en),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .stall            (stall),
    .misalign_err     (misalign_err),
    .data_out         (data_out),
    .alu_out_out      (alu_out_out),
    .rd_out           (rd_out),
    .mem_to_reg_out   (mem_to_reg_out),
    .reg_write_en_out (reg_write_en_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Builds the result byte by byte, independent of the RTL shift-then-extend structure.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] rdat);
    int n;
    logic [63:0] r;
    n = 1 << f3[1:0];
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = rdat[8*(int'(off) + i) +: 8];
    if (!f3[2] && n < 8 && r[8*n-1]) begin
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  task automatic set_idle();
    mem_read = 0; mem_write = 0; funct3 = 0; alu_out = 0; rs2_data = 0;
    rd = 0; mem_to_reg = 0; reg_write_en = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic issue_load(input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] rdat);
    mem_read = 1; mem_write = 0; funct3 = f3; alu_out = addr; rs2_data = 0;
    rd = 5'd9; mem_to_reg = 1; reg_write_en = 1; mem_rdata = rdat;
    exp_q.push_back(ref_load(f3, addr[2:0], rdat));
  endtask

  task automatic test_reset();
    reset_n = 0;
    @(negedge clk);
    set_idle();
    reg_write_en = 1; mem_read = 1; alu_out = 64'h10;
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset stall: got %b want 0", stall); end
    n_vec++; if (reg_write_en_out !== 1'b0) begin n_err++; $display("FAIL reset rwe: got %b want 0", reg_write_en_out); end
    n_vec++; if (data_out !== 64'h0) begin n_err++; $display("FAIL reset data_out: got %h want 0", data_out); end
    @(negedge clk);
    set_idle();
    reset_n = 1;
  endtask

  task automatic test_passthru();
    @(negedge clk);
    set_idle();
    alu_out = 64'h1234; rd = 5'd7; mem_to_reg = 1; reg_write_en = 1;
    mem_ready = 1;  // ignored with no request
    #1;
    n_vec++; if (alu_out_out !== 64'h1234) begin n_err++; $display("FAIL pass alu_out: got %h want 1234", alu_out_out); end
    n_vec++; if (rd_out !== 5'd7) begin n_err++; $display("FAIL pass rd: got %0d want 7", rd_out); end
    n_vec++; if (reg_write_en_out !== 1'b1) begin n_err++; $display("FAIL pass rwe: got %b want 1", reg_write_en_out); end
    n_vec++; if (mem_to_reg_out !== 1'b1) begin n_err++; $display("FAIL pass m2r: got %b want 1", mem_to_reg_out); end
    n_vec++; if ({stall, mem_req} !== 2'b00) begin n_err++; $display("FAIL pass stall/req: got %b want 00", {stall, mem_req}); end
    n_vec++; if (data_out !== 64'h0) begin n_err++; $display("FAIL pass data_out: got %h want 0", data_out); end
    @(negedge clk);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL pass ready_ignored: got stall %b want 0", stall); end
  endtask

  task automatic test_load_wait();
    int stall_cnt;
    logic [63:0] e;
    stall_cnt = 0;
    @(negedge clk);
    issue_load(F3_B, 64'h1005, 64'h0000_8000_0000_0000);
    mem_ready = 0;
    #1;
    n_vec++; if (mem_addr !== 64'h1000) begin n_err++; $display("FAIL ldwait addr: got %h want 1000", mem_addr); end
    n_vec++; if ({mem_req, mem_we, mem_wstrb} !== 10'b10_0000_0000) begin n_err++; $display("FAIL ldwait req/we/strb: got %b want 1000000000", {mem_req, mem_we, mem_wstrb}); end
    n_vec++; if (reg_write_en_out !== 1'b0) begin n_err++; $display("FAIL ldwait rwe_issue: got %b want 0", reg_write_en_out); end
    if (stall === 1'b1) stall_cnt++;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      mem_ready = (i == 2);
      #1;
      if (stall === 1'b1) stall_cnt++;
      n_vec++; if (reg_write_en_out !== 1'b0) begin n_err++; $display("FAIL ldwait rwe_busy: got %b want 0", reg_write_en_out); end
    end
    @(negedge clk);
    mem_ready = 0;
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    n_vec++; if (stall_cnt != 3) begin n_err++; $display("FAIL ldwait stall_cycles: got %0d want 3", stall_cnt); end
    n_vec++; if (data_out !== e || e !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL ldwait data: got %h want %h", data_out, e); end
    n_vec++; if ({stall, mem_req, reg_write_en_out} !== 3'b001) begin n_err++; $display("FAIL ldwait done_ctl: got %b want 001", {stall, mem_req, reg_write_en_out}); end
    @(negedge clk);
    set_idle();
    #1;
    n_vec++; if ({stall, data_out} !== 65'h0) begin n_err++; $display("FAIL ldwait after: got %b/%h want 0/0", stall, data_out); end
  endtask

  task automatic test_store();
    logic [2:0]  f3s  [4] = '{F3_H, F3_B, F3_W, F3_D};
    logic [63:0] adr  [4] = '{64'h2006, 64'h2003, 64'h2004, 64'h2008};
    logic [63:0] wd   [4] = '{64'hABCD_ABCD_ABCD_ABCD, 64'hCDCD_CDCD_CDCD_CDCD,
                              64'h5678_ABCD_5678_ABCD, 64'h1234_5678_5678_ABCD};
    logic [7:0]  st   [4] = '{8'hC0, 8'h08, 8'hF0, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idle();
      mem_write = 1; funct3 = f3s[i]; alu_out = adr[i];
      rs2_data = (i == 0) ? 64'hABCD : 64'h1234_5678_5678_ABCD;
      if (i == 1) rs2_data = 64'hCD;
      reg_write_en = 1; mem_ready = 1;
      #1;
      n_vec++; if (mem_wstrb !== st[i]) begin n_err++; $display("FAIL store%0d wstrb: got %h want %h", i, mem_wstrb, st[i]); end
      n_vec++; if (mem_wdata !== wd[i]) begin n_err++; $display("FAIL store%0d wdata: got %h want %h", i, mem_wdata, wd[i]); end
      n_vec++; if ({mem_req, mem_we, stall} !== 3'b111) begin n_err++; $display("FAIL store%0d req/we/stall: got %b want 111", i, {mem_req, mem_we, stall}); end
      @(negedge clk);
      mem_ready = 0;
      #1;
      n_vec++; if ({stall, mem_req, reg_write_en_out} !== 3'b001 || data_out !== 64'h0) begin n_err++; $display("FAIL store%0d done: got %b/%h want 001/0", i, {stall, mem_req, reg_write_en_out}, data_out); end
    end
    @(negedge clk);
    set_idle();
    #1;
    n_vec++; if ({stall, mem_req} !== 2'b00) begin n_err++; $display("FAIL store idle: got %b want 00", {stall, mem_req}); end
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idle();
      reg_write_en = 1; mem_ready = 1;
      case (i)
        0: begin mem_read = 1; funct3 = F3_W; alu_out = 64'h3002; end
        1: begin mem_write = 1; funct3 = 3'b100; alu_out = 64'h3000; end
        2: begin mem_read = 1; mem_write = 1; funct3 = F3_B; alu_out = 64'h3000; end
        default: begin mem_read = 1; funct3 = F3_D; alu_out = 64'h3004; end
      endcase
      #1;
      n_vec++; if ({misalign_err, mem_req, stall, reg_write_en_out} !== 4'b1000) begin n_err++; $display("FAIL misalign%0d: got err/req/stall/rwe %b want 1000", i, {misalign_err, mem_req, stall, reg_write_en_out}); end
      @(negedge clk);
      set_idle();
      #1;
      n_vec++; if ({misalign_err, stall} !== 2'b00) begin n_err++; $display("FAIL misalign%0d pulse: got %b want 00", i, {misalign_err, stall}); end
    end
    @(negedge clk);
    issue_load(F3_H, 64'h3006, 64'h8001_0000_0000_0000);
    mem_ready = 1;
    #1;
    n_vec++; if ({misalign_err, mem_req} !== 2'b01) begin n_err++; $display("FAIL misalign lh_ok: got %b want 01", {misalign_err, mem_req}); end
    @(negedge clk);
    mem_ready = 0;
    #1;
    n_vec++; if (exp_q.size() == 0 || data_out !== exp_q.pop_front()) begin n_err++; $display("FAIL misalign lh_data: got %h want ffffffffffff8001", data_out); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    issue_load(F3_D, 64'h4000, 64'hFFFF_0000_FFFF_0000);
    mem_ready = 0;
    @(negedge clk);
    #1;
    n_vec++; if ({stall, mem_req} !== 2'b11) begin n_err++; $display("FAIL rstmid busy: got %b want 11", {stall, mem_req}); end
    reset_n = 0;
    #1;
    n_vec++; if ({mem_req, stall, reg_write_en_out, misalign_err} !== 4'b0000 || data_out !== 64'h0) begin n_err++; $display("FAIL rstmid outs: got %b/%h want 0000/0", {mem_req, stall, reg_write_en_out, misalign_err}, data_out); end
    exp_q.delete();
    @(negedge clk);
    set_idle();
    reset_n = 1;
    @(negedge clk);
    #1;
    n_vec++; if ({stall, mem_req} !== 2'b00) begin n_err++; $display("FAIL rstmid idle: got %b want 00", {stall, mem_req}); end
    issue_load(F3_D, 64'h4008, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    #1;
    n_vec++; if (exp_q.size() == 0 || data_out !== exp_q.pop_front() || data_out !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL rstmid ld: got %h want 0123456789abcdef", data_out); end
    n_vec++; if (reg_write_en_out !== 1'b1) begin n_err++; $display("FAIL rstmid rwe: got %b want 1", reg_write_en_out); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) issue_load(F3_WU, 64'h5004, 64'h89AB_CDEF_1234_5678);
      else        issue_load(F3_D, 64'h5008, 64'hFEDC_BA98_7654_3210);
      mem_ready = 1;
      cyc = 1;
      #1;
      n_vec++; if ({stall, mem_req} !== 2'b11) begin n_err++; $display("FAIL b2b%0d issue: got %b want 11", i, {stall, mem_req}); end
      @(negedge clk);
      mem_ready = 0;
      cyc++;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
      n_vec++; if (data_out !== e) begin n_err++; $display("FAIL b2b%0d data: got %h want %h", i, data_out, e); end
      n_vec++; if ({stall, reg_write_en_out} !== 2'b01 || cyc != 2 || rd_out !== 5'd9) begin n_err++; $display("FAIL b2b%0d done: got %b rd %0d want 01 rd 9", i, {stall, reg_write_en_out}, rd_out); end
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_load_sweep();
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] rdat, e;
    int          k, waited;
    for (int t = 0; t < 24; t++) begin
      f3   = 3'($urandom_range(0, 6));
      off  = 3'($urandom_range(0, 7));
      off  = off & ~3'((1 << f3[1:0]) - 1);
      rdat = {$urandom, $urandom};
      k    = $urandom_range(0, 3);
      @(negedge clk);
      issue_load(f3, {48'h0, 13'(t), off}, rdat);
      mem_ready = (k == 0);
      waited = 0;
      while (waited < k) begin
        @(negedge clk);
        waited++;
        mem_ready = (waited == k);
      end
      @(negedge clk);
      mem_ready = 0;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
      n_vec++; if (data_out !== e || stall !== 1'b0) begin n_err++; $display("FAIL sweep%0d f3=%0d off=%0d k=%0d: got %h stall %b want %h stall 0", t, f3, off, k, data_out, stall, e); end
    end
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    set_idle();
    test_reset();
    test_passthru();
    test_load_wait();
    test_store();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_load_sweep();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
